// File: rtl/core_decode_stage.sv
// Instruction-decode stage for an RV32I/RV32E core.
// Decodes the incoming instruction, builds its immediate, and reads both
// operands from a local register file with writeback bypass. Load-use
// hazards stall the input. Results are held in an ID/EX register with
// valid/ready handshakes on both sides.
module core_decode_stage #(
  parameter int XLEN        = 32,
  parameter int NUM_REGS    = 32,
  parameter bit RST_PC_ZERO = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic            i_flush,
  input  logic            i_ex_mem_read,
  input  logic [4:0]      i_ex_rd,
  input  logic            i_wb_reg_write,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_rd_din,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [6:0]      o_opcode,
  output logic [4:0]      o_rd,
  output logic [2:0]      o_funct3,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [6:0]      o_funct7,
  output logic            o_reg_write,
  output logic            o_mem_write,
  output logic            o_mem_read,
  output logic            o_illegal,
  output logic [XLEN-1:0] o_imm,
  output logic [XLEN-1:0] o_rs1_dout,
  output logic [XLEN-1:0] o_rs2_dout
);

  localparam int         IDXW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [5:0] NREGS = 6'(NUM_REGS);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] funct7;

  assign opcode = i_instr[6:0];
  assign rd     = i_instr[11:7];
  assign funct3 = i_instr[14:12];
  assign rs1    = i_instr[19:15];
  assign rs2    = i_instr[24:20];
  assign funct7 = i_instr[31:25];

  // Immediate formats, all pre-sign-extended to 32 bits
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign imm_b = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign imm_u = {i_instr[31:12], 12'b0};
  assign imm_j = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

  // Raw decode results before the illegal-instruction override
  logic        known_op;
  logic        reg_write_raw;
  logic        mem_write_raw;
  logic        mem_read_raw;
  logic        use_rs1;
  logic        use_rs2;
  logic [31:0] imm32;

  // Opcode decode: format selection, control bits and operand usage
  always_comb begin
    known_op      = 1'b1;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    mem_read_raw  = 1'b0;
    use_rs1       = 1'b0;
    use_rs2       = 1'b0;
    imm32         = '0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        reg_write_raw = 1'b1;
        imm32         = imm_u;
      end
      OPC_JAL: begin
        reg_write_raw = 1'b1;
        imm32         = imm_j;
      end
      OPC_JALR: begin
        reg_write_raw = 1'b1;
        use_rs1       = 1'b1;
        imm32         = imm_i;
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = imm_b;
      end
      OPC_LOAD: begin
        reg_write_raw = 1'b1;
        mem_read_raw  = 1'b1;
        use_rs1       = 1'b1;
        imm32         = imm_i;
      end
      OPC_STORE: begin
        mem_write_raw = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        imm32         = imm_s;
      end
      OPC_OPIMM: begin
        reg_write_raw = 1'b1;
        use_rs1       = 1'b1;
        imm32         = imm_i;
      end
      OPC_OP: begin
        reg_write_raw = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OPC_SYSTEM: begin
        // CSR ops write rd; the immediate CSR forms (funct3[2]=1) use rs1 as uimm
        reg_write_raw = (funct3 != 3'b000);
        use_rs1       = ~funct3[2];
        imm32         = imm_i;
      end
      default: begin
        known_op = 1'b0;
      end
    endcase
    if (rd == 5'd0) begin
      reg_write_raw = 1'b0;
    end
  end

  // Register indices beyond the implemented file (RV32E) are illegal when used
  logic rd_bad;
  logic rs1_bad;
  logic rs2_bad;
  logic illegal_d;

  assign rd_bad    = ({1'b0, rd}  >= NREGS);
  assign rs1_bad   = ({1'b0, rs1} >= NREGS);
  assign rs2_bad   = ({1'b0, rs2} >= NREGS);
  assign illegal_d = ~known_op | (use_rs1 & rs1_bad) | (use_rs2 & rs2_bad)
                   | (reg_write_raw & rd_bad);

  // An illegal instruction travels on to EX for trapping but must not side-effect
  logic            reg_write_d;
  logic            mem_write_d;
  logic            mem_read_d;
  logic [XLEN-1:0] imm_d;

  assign reg_write_d = reg_write_raw & ~illegal_d;
  assign mem_write_d = mem_write_raw & ~illegal_d;
  assign mem_read_d  = mem_read_raw  & ~illegal_d;
  assign imm_d       = XLEN'($signed(imm32));

  // Register file: one entry per architectural register, x0 tied to zero
  logic                              wb_en;
  logic [NUM_REGS-1:0][XLEN-1:0]     rf_rd;

  assign wb_en = i_wb_reg_write & (i_wb_rd != 5'd0) & ({1'b0, i_wb_rd} < NREGS);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_rf
      logic [XLEN-1:0] entry_q;
      if (gi == 0) begin : g_zero
        assign entry_q = '0;
      end else begin : g_entry
        // Capture writeback data addressed to this entry; reset clears it
        always_ff @(posedge i_clk) begin
          if (i_rst) begin
            entry_q <= '0;
          end else if (wb_en && (i_wb_rd == 5'(gi))) begin
            entry_q <= i_rd_din;
          end
        end
      end
      assign rf_rd[gi] = entry_q;
    end
  endgenerate

  // Combinational read: out-of-range and x0 read zero, in-flight writeback bypasses
  function automatic logic [XLEN-1:0] rf_read(
    input logic [4:0]                      idx,
    input logic [NUM_REGS-1:0][XLEN-1:0]   rf,
    input logic                            byp_en,
    input logic [4:0]                      byp_idx,
    input logic [XLEN-1:0]                 byp_data
  );
    logic [XLEN-1:0] val;
    val = '0;
    if ((idx != 5'd0) && ({1'b0, idx} < NREGS)) begin
      if (byp_en && (idx == byp_idx)) begin
        val = byp_data;
      end else begin
        val = rf[idx[IDXW-1:0]];
      end
    end
    return val;
  endfunction

  logic [XLEN-1:0] rs1_dout_d;
  logic [XLEN-1:0] rs2_dout_d;

  assign rs1_dout_d = rf_read(rs1, rf_rd, wb_en, i_wb_rd, i_rd_din);
  assign rs2_dout_d = rf_read(rs2, rf_rd, wb_en, i_wb_rd, i_rd_din);

  // Handshake: stall on load-use, back-pressure from EX, or flush
  logic valid_q;
  logic hazard;
  logic accept;

  assign hazard = i_valid & i_ex_mem_read & (i_ex_rd != 5'd0)
                & ((use_rs1 & (rs1 == i_ex_rd)) | (use_rs2 & (rs2 == i_ex_rd)));
  assign o_ready = (~valid_q | i_ready) & ~hazard & ~i_flush;
  assign accept  = i_valid & o_ready;

  // ID/EX register
  logic            reg_write_q;
  logic            mem_write_q;
  logic            mem_read_q;
  logic            illegal_q;
  logic [6:0]      opcode_q;
  logic [4:0]      rd_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rs1_q;
  logic [4:0]      rs2_q;
  logic [6:0]      funct7_q;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] rs1_dout_q;
  logic [XLEN-1:0] rs2_dout_q;

  // Valid and control bits: flush beats accept, accept beats drain-to-bubble
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q     <= 1'b1;
      reg_write_q <= reg_write_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
      illegal_q   <= illegal_d;
    end else if (valid_q && i_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Datapath fields load on accept only; reset clearing is optional
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      if (RST_PC_ZERO) begin
        opcode_q   <= '0;
        rd_q       <= '0;
        funct3_q   <= '0;
        rs1_q      <= '0;
        rs2_q      <= '0;
        funct7_q   <= '0;
        imm_q      <= '0;
        rs1_dout_q <= '0;
        rs2_dout_q <= '0;
      end
    end else if (accept) begin
      opcode_q   <= opcode;
      rd_q       <= rd;
      funct3_q   <= funct3;
      rs1_q      <= rs1;
      rs2_q      <= rs2;
      funct7_q   <= funct7;
      imm_q      <= imm_d;
      rs1_dout_q <= rs1_dout_d;
      rs2_dout_q <= rs2_dout_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_opcode    = opcode_q;
  assign o_rd        = rd_q;
  assign o_funct3    = funct3_q;
  assign o_rs1       = rs1_q;
  assign o_rs2       = rs2_q;
  assign o_funct7    = funct7_q;
  assign o_reg_write = reg_write_q;
  assign o_mem_write = mem_write_q;
  assign o_mem_read  = mem_read_q;
  assign o_illegal   = illegal_q;
  assign o_imm       = imm_q;
  assign o_rs1_dout  = rs1_dout_q;
  assign o_rs2_dout  = rs2_dout_q;

endmodule
